// File: rtl/poly_op_seq.sv
// Polynomial slot sequencer: streams N coefficients from one or two source
// slots through a mod-Q COPY/ADD/SUB/ZERO datapath into a destination slot.
module poly_op_seq #(
  parameter int NUM_SLOTS = 20,
  parameter int Q         = 3329,
  parameter int N         = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  opcode,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  input  logic [4:0]  dst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rd_en,
  output logic [7:0]  rd_addr,
  output logic [4:0]  rd_slot_a,
  output logic [4:0]  rd_slot_b,
  input  logic [11:0] rd_data_a,
  input  logic [11:0] rd_data_b,
  output logic        wr_en,
  output logic [4:0]  wr_slot,
  output logic [7:0]  wr_addr,
  output logic [11:0] wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [1:0]  OP_COPY = 2'd0;
  localparam logic [1:0]  OP_ADD  = 2'd1;
  localparam logic [1:0]  OP_SUB  = 2'd2;
  localparam logic [1:0]  OP_ZERO = 2'd3;
  localparam logic [5:0]  NS      = 6'(NUM_SLOTS);
  localparam logic [12:0] QW      = 13'(Q);
  localparam logic [7:0]  LAST    = 8'(N - 1);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic        iss_v_q, iss_v_d, dv_q, dv_d;
  logic [7:0]  iss_addr_q, iss_addr_d, daddr_q, daddr_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [7:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [4:0]  rd_slot_a_q, rd_slot_a_d, rd_slot_b_q, rd_slot_b_d;
  logic [4:0]  wr_slot_q, wr_slot_d;
  logic [11:0] wr_data_q, wr_data_d;
  logic        reject, uses_a, uses_b;
  logic [12:0] sum, diff, res;

  // Command screening plus the mod-Q arithmetic on the returning read data
  always_comb begin
    uses_a = (opcode != OP_ZERO);
    uses_b = (opcode == OP_ADD) || (opcode == OP_SUB);
    reject = ({1'b0, dst} >= NS)
          || (uses_a && (({1'b0, src_a} >= NS) || (dst == src_a)))
          || (uses_b && (({1'b0, src_b} >= NS) || (dst == src_b)));
    sum  = {1'b0, rd_data_a} + {1'b0, rd_data_b};
    diff = {1'b0, rd_data_a} - {1'b0, rd_data_b};
    res  = 13'd0;
    case (op_q)
      OP_COPY: res = {1'b0, rd_data_a};
      OP_ADD:  res = (sum >= QW) ? sum - QW : sum;
      OP_SUB:  res = (rd_data_a < rd_data_b) ? diff + QW : diff;
      default: res = 13'd0;
    endcase
  end

  // Next-state: FSM, issue counter, two-stage read pipeline, registered outputs
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    dst_d      = dst_q;
    iss_v_d    = iss_v_q;
    iss_addr_d = iss_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    dv_d       = iss_v_q;
    daddr_d    = iss_addr_q;
    wr_en_d    = dv_q;
    wr_addr_d  = dv_q ? daddr_q : 8'd0;
    wr_slot_d  = dv_q ? dst_q : 5'd0;
    wr_data_d  = dv_q ? res[11:0] : 12'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = opcode;
          src_a_d = src_a;
          src_b_d = src_b;
          dst_d   = dst;
          if (reject) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d    = RUN;
            busy_d     = 1'b1;
            iss_v_d    = 1'b1;
            iss_addr_d = 8'd0;
          end
        end
      end
      RUN: begin
        if (iss_addr_q == LAST) begin
          iss_v_d = 1'b0;
          state_d = DRAIN;
        end else begin
          iss_addr_d = iss_addr_q + 8'd1;
        end
      end
      DRAIN: begin
        if (!dv_q) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_en_d     = iss_v_d && (op_d != OP_ZERO);
    rd_addr_d   = rd_en_d ? iss_addr_d : 8'd0;
    rd_slot_a_d = rd_en_d ? src_a_d : 5'd0;
    rd_slot_b_d = rd_en_d ? src_b_d : 5'd0;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 2'd0;
      src_a_q     <= 5'd0;
      src_b_q     <= 5'd0;
      dst_q       <= 5'd0;
      iss_v_q     <= 1'b0;
      iss_addr_q  <= 8'd0;
      dv_q        <= 1'b0;
      daddr_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 8'd0;
      rd_slot_a_q <= 5'd0;
      rd_slot_b_q <= 5'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_slot_q   <= 5'd0;
      wr_data_q   <= 12'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dst_q       <= dst_d;
      iss_v_q     <= iss_v_d;
      iss_addr_q  <= iss_addr_d;
      dv_q        <= dv_d;
      daddr_q     <= daddr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_slot_a_q <= rd_slot_a_d;
      rd_slot_b_q <= rd_slot_b_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_slot_q   <= wr_slot_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign rd_slot_a = rd_slot_a_q;
  assign rd_slot_b = rd_slot_b_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_slot   = wr_slot_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_poly_op_seq.sv
// Directed bench for poly_op_seq with a behavioural slot memory on port B.
module tb_poly_op_seq;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  opcode;
  logic [4:0]  src_a, src_b, dst;
  logic        busy, done, err, rd_en, wr_en;
  logic [7:0]  rd_addr, wr_addr;
  logic [4:0]  rd_slot_a, rd_slot_b, wr_slot;
  logic [11:0] rd_data_a, rd_data_b, wr_data;

  logic [11:0] mem [0:19][0:255];
  logic [11:0] snap_a [0:255];
  logic [11:0] snap_b [0:255];
  logic        init_req;

  int checks = 0;
  int errors = 0;
  int n_wr, first_wr, last_wr, done_cyc, done_cnt, err_cnt;
  int busy_cnt, busy_first, busy_last, rd_cnt, data_bad, seq_bad, hold_bad;

  poly_op_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_slot_a(rd_slot_a), .rd_slot_b(rd_slot_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Initial slot contents, chosen so every test has recognisable data
  function automatic logic [11:0] init_val(input int s, input int k);
    case (s)
      0:  return 12'd3328;
      1:  return 12'd5;
      3:  return 12'(k);
      4:  return 12'd10;
      6:  return 12'((k * 13 + 7) % 3329);
      7:  return 12'd99;
      8:  return 12'd7;
      10: return 12'd55;
      default: return 12'd0;
    endcase
  endfunction

  // Reference mod-Q operation on canonical inputs
  function automatic int model(input logic [1:0] op, input int a, input int b);
    case (op)
      2'd0: return a;
      2'd1: return (a + b >= 3329) ? a + b - 3329 : a + b;
      2'd2: return (a < b) ? a - b + 3329 : a - b;
      default: return 0;
    endcase
  endfunction

  // Slot memory: write-through on wr_en, one-cycle registered reads
  always @(posedge clk) begin
    if (init_req) begin
      for (int s = 0; s < 20; s++)
        for (int k = 0; k < 256; k++)
          mem[s][k] <= init_val(s, k);
    end else begin
      if (wr_en && wr_slot < 5'd20) mem[wr_slot][wr_addr] <= wr_data;
      if (rd_en) begin
        rd_data_a <= (rd_slot_a < 5'd20) ? mem[rd_slot_a][rd_addr] : 12'd0;
        rd_data_b <= (rd_slot_b < 5'd20) ? mem[rd_slot_b][rd_addr] : 12'd0;
      end
    end
  end

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue one command and observe ncyc cycles; optionally pulse start again mid-run
  task automatic apply_stimulus(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] d, input int ncyc, input int inj);
    for (int k = 0; k < 256; k++) begin
      snap_a[k] = (a < 5'd20) ? mem[a][k] : 12'd0;
      snap_b[k] = (b < 5'd20) ? mem[b][k] : 12'd0;
    end
    n_wr = 0; first_wr = -1; last_wr = -1; done_cyc = -1; done_cnt = 0; err_cnt = 0;
    busy_cnt = 0; busy_first = -1; busy_last = -1; rd_cnt = 0;
    data_bad = 0; seq_bad = 0; hold_bad = 0;
    @(negedge clk);
    opcode = op; src_a = a; src_b = b; dst = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done) begin done_cnt++; done_cyc = c; end
      if (err) begin err_cnt++; if (!done) seq_bad++; end
      if (rd_en) begin
        if (int'(rd_addr) != rd_cnt || rd_slot_a != a || rd_slot_b != b) seq_bad++;
        rd_cnt++;
      end else if (rd_addr != 8'd0 || rd_slot_a != 5'd0 || rd_slot_b != 5'd0) hold_bad++;
      if (wr_en) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        if (int'(wr_addr) != n_wr || wr_slot != d) seq_bad++;
        if (int'(wr_data) != model(op, int'(snap_a[wr_addr]), int'(snap_b[wr_addr]))) data_bad++;
        n_wr++;
      end else if (wr_addr != 8'd0 || wr_slot != 5'd0 || wr_data != 12'd0) hold_bad++;
      if (c == inj) begin
        start = 1'b1; opcode = 2'd2; src_a = 5'd3; src_b = 5'd4; dst = 5'd9;
      end else if (c == inj + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_accepted(input string tag, input logic [1:0] op);
    check_output({tag, "_nwr"}, n_wr, N);
    check_output({tag, "_first_wr"}, first_wr, 3);
    check_output({tag, "_last_wr"}, last_wr, N + 2);
    check_output({tag, "_done_cyc"}, done_cyc, N + 3);
    check_output({tag, "_done_cnt"}, done_cnt, 1);
    check_output({tag, "_err_cnt"}, err_cnt, 0);
    check_output({tag, "_busy_cnt"}, busy_cnt, N + 2);
    check_output({tag, "_busy_first"}, busy_first, 1);
    check_output({tag, "_busy_last"}, busy_last, N + 2);
    check_output({tag, "_rd_cnt"}, rd_cnt, (op == 2'd3) ? 0 : N);
    check_output({tag, "_data_bad"}, data_bad, 0);
    check_output({tag, "_seq_bad"}, seq_bad, 0);
    check_output({tag, "_hold_bad"}, hold_bad, 0);
  endtask

  task automatic check_rejected(input string tag);
    check_output({tag, "_done_cyc"}, done_cyc, 1);
    check_output({tag, "_done_cnt"}, done_cnt, 1);
    check_output({tag, "_err_cnt"}, err_cnt, 1);
    check_output({tag, "_nwr"}, n_wr, 0);
    check_output({tag, "_rd_cnt"}, rd_cnt, 0);
    check_output({tag, "_busy_cnt"}, busy_cnt, 0);
    check_output({tag, "_seq_bad"}, seq_bad, 0);
  endtask

  initial begin
    int seen_busy, seen_done;
    rst_n = 1'b0; init_req = 1'b1; start = 1'b0;
    opcode = 2'd0; src_a = 5'd0; src_b = 5'd0; dst = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_ctrl", int'({busy, done, err, rd_en, wr_en}), 0);
    check_output("reset_bus", int'({rd_addr, wr_addr, wr_data, wr_slot, rd_slot_a, rd_slot_b}), 0);
    init_req = 1'b0; rst_n = 1'b1;

    // ADD of 3328 and 5 wraps to 4; a stray SUB start at cycle 40 must be ignored
    apply_stimulus(2'd1, 5'd0, 5'd1, 5'd2, N + 3, 40);
    check_accepted("add", 2'd1);
    check_output("add_mem0", int'(mem[2][0]), 4);
    check_output("add_mem255", int'(mem[2][255]), 4);
    check_output("add_ignored_start", int'(mem[9][0]), 0);

    // SUB started in the cycle right after FIN
    apply_stimulus(2'd2, 5'd3, 5'd4, 5'd5, N + 3, -5);
    check_accepted("sub", 2'd2);
    check_output("sub_mem0", int'(mem[5][0]), 3319);
    check_output("sub_mem10", int'(mem[5][10]), 0);
    check_output("sub_mem255", int'(mem[5][255]), 245);

    // Rejections: COPY onto itself, ADD to an out-of-range slot
    apply_stimulus(2'd0, 5'd6, 5'd0, 5'd6, 3, -5);
    check_rejected("rej_copy");
    apply_stimulus(2'd1, 5'd0, 5'd1, 5'd20, 1, -5);
    check_rejected("rej_add");

    // ZERO accepted in the cycle after a rejection
    apply_stimulus(2'd3, 5'd0, 5'd0, 5'd7, N + 3, -5);
    check_accepted("zero", 2'd3);
    check_output("zero_mem128", int'(mem[7][128]), 0);

    // COPY aborted by reset in cycle 100; start held during reset is ignored
    @(negedge clk);
    opcode = 2'd0; src_a = 5'd6; src_b = 5'd0; dst = 5'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 99; c++) begin
      @(negedge clk);
      if (c == 50) begin start = 1'b1; opcode = 2'd3; dst = 5'd10; end
      if (c == 51) start = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b1; opcode = 2'd0; src_a = 5'd6; dst = 5'd9;
    @(negedge clk);
    @(negedge clk);
    check_output("abort_ctrl", int'({busy, done, err, rd_en, wr_en}), 0);
    check_output("abort_bus", int'({rd_addr, wr_addr, wr_data, wr_slot, rd_slot_a, rd_slot_b}), 0);
    rst_n = 1'b1; start = 1'b0;
    seen_busy = 0; seen_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy) seen_busy++;
      if (done) seen_done++;
    end
    check_output("abort_no_busy", seen_busy, 0);
    check_output("abort_no_done", seen_done, 0);
    check_output("abort_mem50", int'(mem[8][50]), int'(init_val(6, 50)));
    check_output("abort_mem200", int'(mem[8][200]), 7);
    check_output("abort_busy_ign", int'(mem[10][0]), 55);
    check_output("abort_rst_ign", int'(mem[9][0]), 0);

    // The same COPY runs to completion afterwards
    apply_stimulus(2'd0, 5'd6, 5'd0, 5'd8, N + 3, -5);
    check_accepted("copy", 2'd0);
    check_output("copy_mem200", int'(mem[8][200]), int'(init_val(6, 200)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_op_seq.md
POLY_OP_SEQ -- requirements
Module: poly_op_seq

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 20, number of polynomial slots.
REQ-002 SHALL have parameter Q, default 3329, Kyber modulus.
REQ-003 SHALL have parameter N, default 256, coefficients per polynomial.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  command request, sampled in IDLE only.
REQ-007 SHALL have port opcode  input  2  0=COPY, 1=ADD, 2=SUB, 3=ZERO.
REQ-008 SHALL have ports src_a, src_b, dst  input  5 each  slot indices.
REQ-009 SHALL have port busy  output  1  command in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  one-cycle pulse, coincident with done, for a rejected command.
REQ-012 SHALL have ports rd_en  output  1, rd_addr  output  8, rd_slot_a / rd_slot_b  output  5  port-B read request to two slots.
REQ-013 SHALL have ports rd_data_a / rd_data_b  input  12  port-B read data, valid one cycle after rd_en.
REQ-014 SHALL have ports wr_en  output  1, wr_slot  output  5, wr_addr  output  8, wr_data  output  12  port-B write to dst slot.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, FIN.
REQ-016 SHALL, in IDLE with start=1, latch opcode/src_a/src_b/dst; start in any other state SHALL be ignored.
REQ-017 SHALL reject a command when dst>=NUM_SLOTS, or src_a>=NUM_SLOTS or dst==src_a for COPY/ADD/SUB, or src_b>=NUM_SLOTS or dst==src_b for ADD/SUB.
REQ-018 SHALL, for a rejected command sampled at cycle 0, pulse done=1 and err=1 in cycle 1, issue no reads or writes, and return to IDLE.
REQ-019 SHALL, for an accepted command sampled at cycle 0, enter RUN and issue rd_addr=k with rd_en=1 in cycle 1+k, k=0..N-1; rd_en SHALL be 0 throughout for ZERO.
REQ-020 SHALL drive rd_slot_a=src_a and rd_slot_b=src_b (latched) whenever rd_en=1.
REQ-021 SHALL register the result: wr_en=1, wr_addr=k, wr_slot=dst in cycle 3+k; no other cycle has wr_en=1.
REQ-022 SHALL enter DRAIN after issuing addr N-1 until the last write (cycle N+2) completes, then FIN for one cycle.
REQ-023 SHALL hold busy=1 from cycle 1 through cycle N+2 inclusive, pulse done=1 with err=0 in cycle N+3 (FIN) with busy=0, then return to IDLE; start in the cycle after FIN SHALL be accepted.
REQ-024 SHALL compute wr_data: COPY=a; ADD=(a+b>=Q)?a+b-Q:a+b using 13-bit sum; SUB=(a<b)?a-b+Q:a-b using 13-bit arithmetic; ZERO=0.
REQ-025 SHALL produce canonical results in [0,Q-1] for inputs in [0,Q-1]; non-canonical inputs yield unspecified but in-width values.
REQ-026 SHALL hold wr_data, wr_addr, wr_slot, rd_addr, rd_slot_a, rd_slot_b at 0 when their enable is low.
REQ-027 SHALL wrap no address: rd_addr and wr_addr stop at N-1; the 8-bit counter SHALL not roll into a second pass.

Reset
REQ-028 SHALL, when rst_n=0 at a rising edge, enter IDLE and drive busy, done, err, rd_en, wr_en and all address/data/slot outputs to 0 in the following cycle.
REQ-029 SHALL abort an in-progress command on reset without completing remaining writes and without pulsing done; already-written coefficients remain.
REQ-030 SHALL ignore start while rst_n=0.

Verification
REQ-031 ADD src_a=0 (all 3328), src_b=1 (all 5), dst=2 -> 256 writes wr_data=4, addresses 0..255 in cycles 3..258, done in cycle 259.
REQ-032 SUB src_a=3 (coef=k mod Q), src_b=4 (all 10), dst=5 -> addr 0 writes 3319, addr 10 writes 0, addr 255 writes 245.
REQ-033 ZERO dst=7 -> rd_en never asserted, 256 writes of 0, busy high cycles 1..258, done cycle 259.
REQ-034 COPY dst=src_a=6, and ADD dst=20 -> done=err=1 in cycle 1, wr_en never asserted, next start accepted.
REQ-035 COPY started, rst_n=0 in cycle 100 -> outputs 0 next cycle, no done pulse, later COPY completes normally; start pulsed during busy ignored.
